// File: rtl/lifo_pkg.sv
// Shared types for the lifo consumer-side controller.
// Entry width defaults to the lifo's standard data width.
package lifo_pkg;

  localparam int LIFO_DATA_WIDTH = 8;
  localparam int LIFO_LEN_WIDTH  = 4;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    FLUSH
  } lifo_rd_state_t;

  typedef struct packed {
    logic                       last;
    logic [LIFO_DATA_WIDTH-1:0] data;
  } lifo_entry_t;

endpackage

// File: rtl/lifo_out_buf.sv
// Two-entry in-order valid/ready buffer between lifo pops and the stream.
// Fill level is registered so the pop decision never sees out_ready.
module lifo_out_buf
  import lifo_pkg::*;
#(
  parameter type entry_t = lifo_entry_t
) (
  input  logic       clk,
  input  logic       asyn_n_rst,
  input  logic       push,
  input  entry_t     push_entry,
  input  logic       flush,
  input  logic       out_ready,
  output logic       out_valid,
  output entry_t     out_entry,
  output logic [1:0] cnt
);

  logic [1:0] cnt_q;
  logic [1:0] cnt_d;
  entry_t     e0_q;
  entry_t     e0_d;
  entry_t     e1_q;
  entry_t     e1_d;
  logic       hs;

  always_comb begin
    hs    = (cnt_q != 2'd0) && out_ready;
    cnt_d = cnt_q;
    e0_d  = e0_q;
    e1_d  = e1_q;
    if (flush) begin
      cnt_d = 2'd0;
    end else begin
      unique case ({push, hs})
        2'b11: begin
          if (cnt_q == 2'd2) begin
            e0_d = e1_q;
            e1_d = push_entry;
          end else begin
            e0_d = push_entry;
          end
        end
        2'b10: begin
          if (cnt_q == 2'd0) begin
            e0_d = push_entry;
          end else begin
            e1_d = push_entry;
          end
          cnt_d = cnt_q + 2'd1;
        end
        2'b01: begin
          e0_d  = e1_q;
          cnt_d = cnt_q - 2'd1;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge asyn_n_rst) begin
    if (!asyn_n_rst) begin
      cnt_q <= 2'd0;
      e0_q  <= '0;
      e1_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      e0_q  <= e0_d;
      e1_q  <= e1_d;
    end
  end

  assign out_valid = (cnt_q != 2'd0);
  assign out_entry = e0_q;
  assign cnt       = cnt_q;

endmodule

// File: rtl/lifo_burst_reader.sv
// Drains a burst of words from a lifo into a valid/ready stream,
// tagging the final word and reporting done/short on completion.
module lifo_burst_reader
  import lifo_pkg::*;
#(
  parameter int DATA_WIDTH = LIFO_DATA_WIDTH,
  parameter int LEN_WIDTH  = LIFO_LEN_WIDTH
) (
  input  logic                  clk,
  input  logic                  asyn_n_rst,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  burst_len,
  input  logic                  stop_on_empty,
  input  logic                  abort,
  input  logic                  lifo_empty,
  input  logic [DATA_WIDTH-1:0] lifo_data,
  output logic                  lifo_pop,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic                  short,
  output logic [LEN_WIDTH-1:0]  popped_cnt
);

  typedef struct packed {
    logic                  last;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  lifo_rd_state_t       state_q;
  lifo_rd_state_t       state_d;
  logic [LEN_WIDTH-1:0] len_q;
  logic [LEN_WIDTH-1:0] len_d;
  logic [LEN_WIDTH-1:0] popped_q;
  logic [LEN_WIDTH-1:0] popped_d;
  logic                 soe_q;
  logic                 soe_d;
  logic                 done_q;
  logic                 done_d;
  logic                 short_q;
  logic                 short_d;
  logic                 spend_q;
  logic                 spend_d;

  logic                 pop;
  logic                 flush;
  logic                 hs;
  logic                 last_pop;
  logic [1:0]           buf_cnt;
  logic                 buf_valid;
  entry_t               push_entry;
  entry_t               head;

  assign hs         = buf_valid && out_ready;
  assign last_pop   = (popped_q + LEN_WIDTH'(1)) == len_q;
  assign push_entry = '{last: last_pop, data: lifo_data};

  // spend_q remembers whether the flush phase ends a short burst
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    soe_d    = soe_q;
    popped_d = popped_q;
    done_d   = 1'b0;
    short_d  = short_q;
    spend_d  = spend_q;
    pop      = 1'b0;
    flush    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && burst_len != '0) begin
          len_d    = burst_len;
          soe_d    = stop_on_empty;
          popped_d = '0;
          spend_d  = 1'b0;
          state_d  = DRAIN;
        end else if (start) begin
          done_d  = 1'b1;
          short_d = 1'b0;
        end
      end
      DRAIN: begin
        pop = !lifo_empty
           && (buf_cnt < 2'd2)
           && (popped_q < len_q)
           && !abort;
        if (abort) begin
          flush   = 1'b1;
          done_d  = 1'b1;
          short_d = 1'b1;
          state_d = IDLE;
        end else if (pop) begin
          popped_d = popped_q + LEN_WIDTH'(1);
          if (last_pop) begin
            spend_d = 1'b0;
            state_d = FLUSH;
          end
        end else if (lifo_empty && soe_q) begin
          spend_d = 1'b1;
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (abort) begin
          flush   = 1'b1;
          done_d  = 1'b1;
          short_d = 1'b1;
          state_d = IDLE;
        end else if (buf_cnt == 2'd0
                  || (buf_cnt == 2'd1 && hs)) begin
          done_d  = 1'b1;
          short_d = spend_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge asyn_n_rst) begin
    if (!asyn_n_rst) begin
      state_q  <= IDLE;
      len_q    <= '0;
      popped_q <= '0;
      soe_q    <= 1'b0;
      done_q   <= 1'b0;
      short_q  <= 1'b0;
      spend_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      popped_q <= popped_d;
      soe_q    <= soe_d;
      done_q   <= done_d;
      short_q  <= short_d;
      spend_q  <= spend_d;
    end
  end

  lifo_out_buf #(
    .entry_t(entry_t)
  ) u_buf (
    .clk       (clk),
    .asyn_n_rst(asyn_n_rst),
    .push      (pop),
    .push_entry(push_entry),
    .flush     (flush),
    .out_ready (out_ready),
    .out_valid (buf_valid),
    .out_entry (head),
    .cnt       (buf_cnt)
  );

  assign lifo_pop   = pop;
  assign out_valid  = buf_valid;
  assign out_data   = head.data;
  assign out_last   = head.last;
  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign short      = short_q;
  assign popped_cnt = popped_q;

endmodule
